// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and command-field positions for the SPI register transceiver
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_DESELECT,
        IDLE,
        CMD,
        DATA
    } state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_REG_MSB   = 6;

endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect: one-cycle rise/fall pulses from an already-synchronized sck
module spi_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic sck_prev_q, sck_prev_d;

    // previous sck level is simply the current one
    always_comb sck_prev_d = sck;

    // remember last sck level; mode 0 idles low so reset to 0
    always_ff @(posedge clk) begin
        if (reset) sck_prev_q <= 1'b0;
        else       sck_prev_q <= sck_prev_d;
    end

    assign rise_pulse = !sck_prev_q && sck;
    assign fall_pulse = sck_prev_q && !sck;

endmodule

// File: rtl/spi_register_transceiver.sv
// spi_register_transceiver: SPI mode-0 slave framing a command byte followed by burst data words
module spi_register_transceiver
    import spi_pkg::*;
#(
    parameter int CMD_WIDTH  = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] word_to_output,
    output logic [WORD_WIDTH-1:0] word_received,
    output logic [CMD_WIDTH-1:0]  command,
    output logic                  command_ready,
    output logic                  word_rx_complete,
    output logic                  frame_aborted,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs,
    output logic                  sdo
);

    localparam int MAX_W = (CMD_WIDTH > WORD_WIDTH) ? CMD_WIDTH : WORD_WIDTH;
    localparam int CW    = $clog2(MAX_W + 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CMD_WIDTH-1:0]  cmd_sr_q, cmd_sr_d;
    logic [WORD_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WORD_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [CMD_WIDTH-1:0]  command_q, command_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  cmd_rdy_q, cmd_rdy_d;
    logic                  wrx_q, wrx_d;
    logic                  abort_q, abort_d;
    logic                  cs_prev_q, cs_prev_d;
    logic                  rise, fall, deselect;

    spi_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .rise_pulse (rise),
        .fall_pulse (fall)
    );

    // deselect beats any sck edge in the same cycle, so a completing bit is dropped
    assign deselect = cs && (state_q == CMD || state_q == DATA);

    // framing FSM: next state, shift registers, held outputs and one-cycle pulses
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_sr_d  = cmd_sr_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        command_d = command_q;
        word_d    = word_q;
        cmd_rdy_d = 1'b0;
        wrx_d     = 1'b0;
        abort_d   = 1'b0;
        cs_prev_d = cs;
        if (deselect) begin
            state_d = IDLE;
            tx_sr_d = '0;
            abort_d = (cnt_q != '0);
        end else begin
            case (state_q)
                WAIT_DESELECT: state_d = cs ? IDLE : WAIT_DESELECT;
                IDLE: if (!cs && cs_prev_q) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    tx_sr_d = '0;
                end
                CMD: if (rise) begin
                    cmd_sr_d = {cmd_sr_q[CMD_WIDTH-2:0], sdi};
                    if (cnt_q == CW'(CMD_WIDTH - 1)) begin
                        command_d = cmd_sr_d;
                        cmd_rdy_d = 1'b1;
                        state_d   = DATA;
                        cnt_d     = '0;
                    end else cnt_d = cnt_q + CW'(1);
                end
                DATA: if (rise) begin
                    rx_sr_d = {rx_sr_q[WORD_WIDTH-2:0], sdi};
                    if (cnt_q == CW'(WORD_WIDTH - 1)) begin
                        word_d = rx_sr_d;
                        wrx_d  = 1'b1;
                        cnt_d  = '0;
                    end else cnt_d = cnt_q + CW'(1);
                end else if (fall) begin
                    tx_sr_d = (cnt_q == '0) ? word_to_output : {tx_sr_q[WORD_WIDTH-2:0], 1'b0};
                end
                default: state_d = WAIT_DESELECT;
            endcase
        end
    end

    // state and datapath registers; reset parks in WAIT_DESELECT so a low cs never decodes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_DESELECT;
            cnt_q     <= '0;
            cmd_sr_q  <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            command_q <= '0;
            word_q    <= '0;
            cmd_rdy_q <= 1'b0;
            wrx_q     <= 1'b0;
            abort_q   <= 1'b0;
            cs_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_sr_q  <= cmd_sr_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            command_q <= command_d;
            word_q    <= word_d;
            cmd_rdy_q <= cmd_rdy_d;
            wrx_q     <= wrx_d;
            abort_q   <= abort_d;
            cs_prev_q <= cs_prev_d;
        end
    end

    assign command          = command_q;
    assign word_received    = word_q;
    assign command_ready    = cmd_rdy_q;
    assign word_rx_complete = wrx_q;
    assign frame_aborted    = abort_q;
    assign sdo              = tx_sr_q[WORD_WIDTH-1];

endmodule
